id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  Decode-side operand stage and ID/EX pipeline register of the pipelined MIPS core.
//  - Drives the register file read addresses and resolves both source operands.
//  - Forwards results from the EX and MEM stages.
//  - Detects load-use hazards and inserts bubbles.
//  - Registers the resolved instruction bundle for the EX stage.
//  The register file writes on the falling clock edge, so a WB write reaches rf_data1/2 in the same cycle. No WB bypass exists here.
// PARAMETERS
//  DW    32  datapath width
//  CW    16  width of opaque EX/MEM/WB control bundle
//  CNTW  16  width of saturating load-use stall counter
// PORTS
//  clk            in   1    clock, all state updates on rising edge
//  reset          in   1    synchronous, active-high
//  id_valid       in   1    ID holds a real instruction
//  id_rs/id_rt    in   5    source register numbers
//  id_uses_rs/rt  in   1    instruction reads rs / rt
//  id_dst         in   5    destination register number
//  id_wr          in   1    instruction writes id_dst
//  id_is_load     in   1    instruction is a load
//  id_ctrl        in   CW   control bundle, passed through
//  id_imm/id_pc   in   DW   extended immediate / PC+4, passed through
//  rf_addr1/2     out  5    register file read addresses (= id_rs / id_rt)
//  rf_data1/2     in   DW   register file read data (reg 0 reads 0)
//  ex_result      in   DW   ALU result of the instruction currently in EX
//  mem_valid/wr   in   1    MEM-stage instruction valid / writes register
//  mem_dst        in   5    MEM-stage destination
//  mem_result     in   DW   final MEM-stage value (load data already merged)
//  ex_flush       in   1    EX redirects the PC; squash the ID instruction
//  ex_hold        in   1    downstream busy; freeze the front end
//  stall_id       out  1    hold PC and IF/ID this cycle (combinational)
//  idex_valid     out  1    registered bundle to EX: valid
//  idex_a/idex_b  out  DW   resolved operands
//  idex_dst/wr/is_load/ctrl/imm/pc  out  registered copies of the id_* fields
//  stall_cnt      out  CNTW count of load-use stall cycles
// BEHAVIOUR
//  - Reset: every idex_* output and stall_cnt are 0. stall_id is 0 while reset is high.
//  - Latency: 1 cycle. Fields presented in ID at cycle n appear on idex_* after edge n+1.
//  - Operand select for rs (rt is identical), highest priority first:
//    1. id_rs==0 -> 0.
//    2. idex_valid & idex_wr & idex_dst==id_rs & !idex_is_load -> ex_result.
//    3. mem_valid & mem_wr & mem_dst==id_rs -> mem_result.
//    4. Otherwise -> rf_data1.
//  - load_use = id_valid & idex_valid & idex_is_load & idex_wr & idex_dst!=0
//    & ((id_uses_rs & id_rs==idex_dst) | (id_uses_rt & id_rt==idex_dst)).
//  - Per-cycle events, evaluated in this priority order:
//    1. reset: clear all state.
//    2. ex_flush: capture a bubble. stall_id=0. Counter unchanged.
//    3. ex_hold: all idex_* hold their values. stall_id=1. Counter unchanged.
//    4. load_use: capture a bubble. stall_id=1. stall_cnt+1.
//    5. Otherwise: capture the ID bundle with resolved operands. stall_id=0.
//  - Bubble: idex_valid, idex_wr, idex_is_load and idex_ctrl are 0. Data fields are don't-care but deterministic (0).
//  - id_valid=0 captures a bubble and never raises load_use.
//  - After a load-use bubble, the load is in MEM and the dependent instruction takes mem_result.
//  - stall_cnt saturates at 2^CNTW-1 and does not wrap.
//  - Reset mid-stall: the bubble and stall are dropped. The next cycle after reset is normal capture.
// TESTING
//  1. reset high 2 cycles with id_valid=1, id_wr=1 -> all idex_*=0, stall_cnt=0, stall_id=0.
//  2. Cycle n: capture dst=8, wr=1. Cycle n+1: id_rs=8, ex_result=0x1234, rf_data1=0xDEAD -> idex_a=0x1234.
//  3. EX dst=9 and MEM dst=9, ex_result=0x11, mem_result=0x22, id_rt=9 -> idex_b=0x11.
//     EX dst=0 with wr=1 and id_rs=0 -> idex_a=0.
//  4. lw $4 in EX, ID reads rs=4:
//     -> stall_id=1 for 1 cycle, bubble captured, stall_cnt=1.
//     -> Next cycle: mem_result=0xCAFE is forwarded, idex_a=0xCAFE.
//  5. load_use and ex_flush in the same cycle -> bubble, stall_id=0, stall_cnt unchanged.
//     ex_hold for 3 cycles -> idex_* stable, stall_id=1 throughout.
//  6. CNTW=4: 17 consecutive load-use stalls -> stall_cnt=15 and stays at 15.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID-side operand resolution with EX/MEM forwarding, the load-use interlock
// and the ID/EX pipeline register feeding the EX stage.
module id_ex_operand_stage #(
  parameter int DW   = 32,
  parameter int CW   = 16,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic [4:0]      id_dst,
  input  logic            id_wr,
  input  logic            id_is_load,
  input  logic [CW-1:0]   id_ctrl,
  input  logic [DW-1:0]   id_imm,
  input  logic [DW-1:0]   id_pc,
  output logic [4:0]      rf_addr1,
  output logic [4:0]      rf_addr2,
  input  logic [DW-1:0]   rf_data1,
  input  logic [DW-1:0]   rf_data2,
  input  logic [DW-1:0]   ex_result,
  input  logic            mem_valid,
  input  logic            mem_wr,
  input  logic [4:0]      mem_dst,
  input  logic [DW-1:0]   mem_result,
  input  logic            ex_flush,
  input  logic            ex_hold,
  output logic            stall_id,
  output logic            idex_valid,
  output logic [DW-1:0]   idex_a,
  output logic [DW-1:0]   idex_b,
  output logic [4:0]      idex_dst,
  output logic            idex_wr,
  output logic            idex_is_load,
  output logic [CW-1:0]   idex_ctrl,
  output logic [DW-1:0]   idex_imm,
  output logic [DW-1:0]   idex_pc,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic [1:0] {ACT_CAPTURE, ACT_BUBBLE, ACT_HOLD} act_e;

  logic            idex_valid_r, idex_wr_r, idex_is_load_r;
  logic [DW-1:0]   idex_a_r, idex_b_r, idex_imm_r, idex_pc_r;
  logic [4:0]      idex_dst_r;
  logic [CW-1:0]   idex_ctrl_r;
  logic [CNTW-1:0] stall_cnt_r;
  logic [DW-1:0]   opnd_a_s, opnd_b_s;
  logic            ex_fwd_ok_s, mem_fwd_ok_s, load_use_s, stall_id_s, cnt_inc_s;
  act_e            act_s;

  // A load still in EX has no result yet, so it never forwards from EX.
  function automatic logic [DW-1:0] resolve_opnd(
    input logic [4:0]    src,
    input logic          ex_ok,
    input logic [4:0]    ex_dst,
    input logic [DW-1:0] ex_val,
    input logic          mem_ok,
    input logic [4:0]    mem_d,
    input logic [DW-1:0] mem_val,
    input logic [DW-1:0] rf_val
  );
    logic [DW-1:0] res;
    if (src == 5'd0) begin
      res = {DW{1'b0}};
    end else if (ex_ok && (ex_dst == src)) begin
      res = ex_val;
    end else if (mem_ok && (mem_d == src)) begin
      res = mem_val;
    end else begin
      res = rf_val;
    end
    return res;
  endfunction

  assign ex_fwd_ok_s  = idex_valid_r & idex_wr_r & ~idex_is_load_r;
  assign mem_fwd_ok_s = mem_valid & mem_wr;
  assign opnd_a_s = resolve_opnd(id_rs, ex_fwd_ok_s, idex_dst_r, ex_result,
                                 mem_fwd_ok_s, mem_dst, mem_result, rf_data1);
  assign opnd_b_s = resolve_opnd(id_rt, ex_fwd_ok_s, idex_dst_r, ex_result,
                                 mem_fwd_ok_s, mem_dst, mem_result, rf_data2);

  assign load_use_s = id_valid & idex_valid_r & idex_is_load_r & idex_wr_r
                    & (idex_dst_r != 5'd0)
                    & ((id_uses_rs & (id_rs == idex_dst_r))
                     | (id_uses_rt & (id_rt == idex_dst_r)));

  // Event priority: flush beats hold beats load-use beats normal capture.
  always_comb begin
    act_s      = ACT_BUBBLE;
    stall_id_s = 1'b0;
    cnt_inc_s  = 1'b0;
    if (reset || ex_flush) begin
      act_s = ACT_BUBBLE;
    end else if (ex_hold) begin
      act_s      = ACT_HOLD;
      stall_id_s = 1'b1;
    end else if (load_use_s) begin
      act_s      = ACT_BUBBLE;
      stall_id_s = 1'b1;
      cnt_inc_s  = (stall_cnt_r != {CNTW{1'b1}});
    end else if (!id_valid) begin
      act_s = ACT_BUBBLE;
    end else begin
      act_s = ACT_CAPTURE;
    end
  end

  // ID/EX pipeline register and saturating load-use stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_valid_r   <= 1'b0;
      idex_a_r       <= {DW{1'b0}};
      idex_b_r       <= {DW{1'b0}};
      idex_dst_r     <= 5'd0;
      idex_wr_r      <= 1'b0;
      idex_is_load_r <= 1'b0;
      idex_ctrl_r    <= {CW{1'b0}};
      idex_imm_r     <= {DW{1'b0}};
      idex_pc_r      <= {DW{1'b0}};
      stall_cnt_r    <= {CNTW{1'b0}};
    end else begin
      case (act_s)
        ACT_CAPTURE: begin
          idex_valid_r   <= 1'b1;
          idex_a_r       <= opnd_a_s;
          idex_b_r       <= opnd_b_s;
          idex_dst_r     <= id_dst;
          idex_wr_r      <= id_wr;
          idex_is_load_r <= id_is_load;
          idex_ctrl_r    <= id_ctrl;
          idex_imm_r     <= id_imm;
          idex_pc_r      <= id_pc;
        end
        ACT_HOLD: begin
          idex_valid_r <= idex_valid_r;
        end
        default: begin
          idex_valid_r   <= 1'b0;
          idex_a_r       <= {DW{1'b0}};
          idex_b_r       <= {DW{1'b0}};
          idex_dst_r     <= 5'd0;
          idex_wr_r      <= 1'b0;
          idex_is_load_r <= 1'b0;
          idex_ctrl_r    <= {CW{1'b0}};
          idex_imm_r     <= {DW{1'b0}};
          idex_pc_r      <= {DW{1'b0}};
        end
      endcase
      if (cnt_inc_s) begin
        stall_cnt_r <= stall_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign rf_addr1     = id_rs;
  assign rf_addr2     = id_rt;
  assign stall_id     = stall_id_s;
  assign idex_valid   = idex_valid_r;
  assign idex_a       = idex_a_r;
  assign idex_b       = idex_b_r;
  assign idex_dst     = idex_dst_r;
  assign idex_wr      = idex_wr_r;
  assign idex_is_load = idex_is_load_r;
  assign idex_ctrl    = idex_ctrl_r;
  assign idex_imm     = idex_imm_r;
  assign idex_pc      = idex_pc_r;
  assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: a behavioural model pushes the
// expected ID/EX bundle per cycle, popped and compared after the clock edge.
module tb_id_ex_operand_stage;
  localparam int DW = 32, CW = 16, CNTW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, id_valid, id_uses_rs, id_uses_rt, id_wr, id_is_load;
  logic [4:0] id_rs, id_rt, id_dst, rf_addr1, rf_addr2, mem_dst, idex_dst;
  logic [CW-1:0] id_ctrl, idex_ctrl;
  logic [DW-1:0] id_imm, id_pc, rf_data1, rf_data2, ex_result, mem_result;
  logic [DW-1:0] idex_a, idex_b, idex_imm, idex_pc;
  logic mem_valid, mem_wr, ex_flush, ex_hold, stall_id;
  logic idex_valid, idex_wr, idex_is_load;
  logic [CNTW-1:0] stall_cnt;

  id_ex_operand_stage #(.DW(DW), .CW(CW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_wr(id_wr),
    .id_is_load(id_is_load), .id_ctrl(id_ctrl), .id_imm(id_imm), .id_pc(id_pc),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_result(ex_result), .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_dst(mem_dst),
    .mem_result(mem_result), .ex_flush(ex_flush), .ex_hold(ex_hold), .stall_id(stall_id),
    .idex_valid(idex_valid), .idex_a(idex_a), .idex_b(idex_b), .idex_dst(idex_dst),
    .idex_wr(idex_wr), .idex_is_load(idex_is_load), .idex_ctrl(idex_ctrl),
    .idex_imm(idex_imm), .idex_pc(idex_pc), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic v; logic [DW-1:0] a; logic [DW-1:0] b; logic [4:0] dst;
    logic wr; logic ld; logic [CW-1:0] ctrl; logic [DW-1:0] imm; logic [DW-1:0] pc;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int checks = 0, errors = 0;
  logic [DW-1:0] snap_a, snap_pc;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_opnd(input logic [4:0] src, input logic [DW-1:0] rf);
    if (src == 5'd0) return '0;
    if (m.v && m.wr && !m.ld && m.dst == src) return ex_result;
    if (mem_valid && mem_wr && mem_dst == src) return mem_result;
    return rf;
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic wr, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dst = dst; id_wr = wr; id_is_load = ld;
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic cyc();
    exp_t n, e;
    logic lu, st;
    id_ctrl = CW'($urandom); id_imm = $urandom; id_pc = $urandom;
    #1;
    lu = id_valid && m.v && m.ld && m.wr && (m.dst != 5'd0) &&
         ((id_uses_rs && id_rs == m.dst) || (id_uses_rt && id_rt == m.dst));
    st = !reset && !ex_flush && (ex_hold || lu);
    check_val("stall_id", stall_id, st);
    check_val("rf_addr", {rf_addr1, rf_addr2}, {id_rs, id_rt});
    n = m;
    if (reset) n = '0;
    else if (ex_flush) begin n = '0; n.cnt = m.cnt; end
    else if (ex_hold) n = m;
    else if (lu) begin n = '0; n.cnt = (m.cnt == '1) ? m.cnt : m.cnt + 1'b1; end
    else if (!id_valid) begin n = '0; n.cnt = m.cnt; end
    else n = '{1'b1, ref_opnd(id_rs, rf_data1), ref_opnd(id_rt, rf_data2), id_dst,
               id_wr, id_is_load, id_ctrl, id_imm, id_pc, m.cnt};
    sb_q.push_back(n);
    m = n;
    @(posedge clk); #1;
    e = sb_q.pop_front();
    check_val("idex_valid", idex_valid, e.v);
    check_val("idex_a", idex_a, e.a);
    check_val("idex_b", idex_b, e.b);
    check_val("idex_dst_wr_ld", {idex_dst, idex_wr, idex_is_load}, {e.dst, e.wr, e.ld});
    check_val("idex_ctrl", idex_ctrl, e.ctrl);
    check_val("idex_imm_pc", {idex_imm, idex_pc}, {e.imm, e.pc});
    check_val("stall_cnt", stall_cnt, e.cnt);
  endtask

  initial begin
    m = '0;
    reset = 1'b1; ex_flush = 1'b0; ex_hold = 1'b0;
    mem_valid = 1'b0; mem_wr = 1'b0; mem_dst = 5'd0; mem_result = '0;
    ex_result = '0; rf_data1 = '0; rf_data2 = '0;
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    cyc(); cyc();
    check_val("rst_valid", idex_valid, 1'b0);
    check_val("rst_cnt", stall_cnt, 4'd0);
    reset = 1'b0;

    // EX forwarding beats the register file
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0); rf_data1 = 32'h10; rf_data2 = 32'h20;
    cyc();
    set_id(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    ex_result = 32'h1234; rf_data1 = 32'hDEAD;
    cyc();
    check_val("fwd_ex_a", idex_a, 32'h1234);

    // EX beats MEM; register 0 never forwards
    set_id(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    cyc();
    mem_valid = 1'b1; mem_wr = 1'b1; mem_dst = 5'd9; mem_result = 32'h22; ex_result = 32'h11;
    set_id(1'b1, 5'd6, 5'd9, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0); rf_data2 = 32'h33;
    cyc();
    check_val("fwd_ex_over_mem_b", idex_b, 32'h11);
    mem_valid = 1'b0;
    set_id(1'b1, 5'd0, 5'd7, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0); ex_result = 32'h55; rf_data1 = '0;
    cyc();
    check_val("r0_a", idex_a, 32'h0);

    // Load-use: one stall, then MEM forwarding
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1);
    cyc();
    set_id(1'b1, 5'd4, 5'd2, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0); rf_data1 = 32'hBAD;
    cyc();
    check_val("lu_bubble", idex_valid, 1'b0);
    check_val("lu_cnt", stall_cnt, 4'd1);
    mem_valid = 1'b1; mem_wr = 1'b1; mem_dst = 5'd4; mem_result = 32'hCAFE;
    cyc();
    check_val("lu_mem_a", idex_a, 32'hCAFE);
    mem_valid = 1'b0;

    // id_valid=0 never stalls
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1);
    cyc();
    set_id(1'b0, 5'd4, 5'd4, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
    cyc();

    // Flush overrides load-use
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1);
    cyc();
    set_id(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0); ex_flush = 1'b1;
    cyc();
    check_val("flush_cnt", stall_cnt, 4'd1);
    check_val("flush_bubble", idex_valid, 1'b0);
    ex_flush = 1'b0;

    // Hold freezes the register for 3 cycles
    set_id(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0); rf_data1 = 32'h77;
    cyc();
    snap_a = idex_a; snap_pc = idex_pc;
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'(i + 1), 5'd7, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0); rf_data1 = $urandom;
      cyc();
      check_val("hold_a", idex_a, snap_a);
      check_val("hold_pc", idex_pc, snap_pc);
    end
    ex_hold = 1'b0;

    // Counter saturates at 15
    for (int i = 0; i < 17; i++) begin
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
      cyc();
      set_id(1'b1, 5'd6, 5'd3, 1'b0, 1'b1, 5'd14, 1'b1, 1'b0);
      cyc();
    end
    check_val("sat_cnt", stall_cnt, 4'd15);

    // Reset during a load-use stall drops it
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
    cyc();
    set_id(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0); reset = 1'b1;
    cyc();
    check_val("rst_mid_cnt", stall_cnt, 4'd0);
    reset = 1'b0;
    cyc();
    check_val("post_rst_capture", idex_valid, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
